ycbcr2rgb: RTL and testbench

Pipelined YCbCr-to-RGB colour-space converter on the decoder side of the JPEG path. It takes three `dctPort_t` lanes of level-shifted YCbCr samples from the inverse-transform/upsampling stage and produces three `dctPort_t` lanes of RGB pixels, clamped to 0..255. It is the inverse of the encoder's RGB-to-YCbCr stage and uses the same lane ordering and Q8 fixed-point convention. It adds a global-stall backpressure handshake and an optional sop/eop protocol checker.

---
 rtl/ycbcr2rgb_if.sv | 31 +++
 rtl/ycbcr2rgb.sv | 149 ++++++++++++++
 tb/tb_ycbcr2rgb.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ycbcr2rgb_if.sv
// Stream bundle for ycbcr2rgb: three dctPort_t lanes in each direction plus the
// global-stall handshake (in_ready mirrors out_ready).
interface ycbcr2rgb_if #(
  parameter int DATA_WIDTH = 10
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  sop;
    logic                  eop;
  } dctPort_t;

  dctPort_t in  [3];
  dctPort_t out [3];
  logic     in_ready;
  logic     out_ready;

  modport master (
    output in,
    input  in_ready,
    input  out,
    output out_ready
  );

  modport slave (
    input  in,
    output in_ready,
    output out,
    input  out_ready
  );
endinterface

// File: rtl/ycbcr2rgb.sv
// Pipelined YCbCr-to-RGB converter (Q8 constants, round-half-up, clamp 0..255).
// Define YCBCR2RGB_PROTO_EN to build the sop/eop protocol checker driving proto_err.
module ycbcr2rgb #(
  parameter int DATA_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  ycbcr2rgb_if.slave  bus,
  output logic        proto_err
);
  localparam int SW = DATA_WIDTH + 1;
  localparam int PW = DATA_WIDTH + 11;

  localparam logic signed [PW-1:0] K_R   = PW'(359);
  localparam logic signed [PW-1:0] K_GB  = PW'(88);
  localparam logic signed [PW-1:0] K_GR  = PW'(183);
  localparam logic signed [PW-1:0] K_B   = PW'(454);
  localparam logic signed [PW-1:0] HALF  = PW'(128);
  localparam logic signed [PW-1:0] ZERO  = '0;
  localparam logic signed [PW-1:0] MAX8  = PW'(255);

  logic en, accept, sop_in, eop_in;

  logic        [7:0]    y_p0, cr_p0, cb_p0;
  logic        [7:0]    y_p1;
  logic signed [SW-1:0] cb_p1, cr_p1;
  logic signed [PW-1:0] ys_p2, pr_p2, pgb_p2, pgr_p2, pb_p2;
  logic signed [PW-1:0] r_p3, g_p3, b_p3;
  logic vld_p0, vld_p1, vld_p2, vld_p3;
  logic sop_p0, sop_p1, sop_p2, sop_p3;
  logic eop_p0, eop_p1, eop_p2, eop_p3;

  function automatic logic signed [PW-1:0] round_q8(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] t;
    t = v + HALF;
    return t >>> 8;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sat_u8(input logic signed [PW-1:0] v);
    if (v < ZERO)      return '0;
    else if (v > MAX8) return DATA_WIDTH'(8'hFF);
    else               return DATA_WIDTH'(v[7:0]);
  endfunction

  assign en           = bus.out_ready;
  assign bus.in_ready = bus.out_ready;
  assign accept = bus.in[0].valid & bus.in[1].valid & bus.in[2].valid & bus.in_ready;
  assign sop_in = bus.in[0].sop | bus.in[1].sop | bus.in[2].sop;
  assign eop_in = bus.in[0].eop | bus.in[1].eop | bus.in[2].eop;

  always_ff @(posedge clk) begin
    if (en) begin
      // p0: capture raw samples
      y_p0  <= bus.in[0].data[7:0];
      cr_p0 <= bus.in[1].data[7:0];
      cb_p0 <= bus.in[2].data[7:0];
      // p1: remove chroma offset
      y_p1  <= y_p0;
      cb_p1 <= SW'(cb_p0) - SW'(128);
      cr_p1 <= SW'(cr_p0) - SW'(128);
      // p2: Q8 products
      ys_p2  <= PW'(y_p1) << 8;
      pr_p2  <= PW'(cr_p1) * K_R;
      pgb_p2 <= PW'(cb_p1) * K_GB;
      pgr_p2 <= PW'(cr_p1) * K_GR;
      pb_p2  <= PW'(cb_p1) * K_B;
      // p3: sums, rounded back to integer
      r_p3 <= round_q8(ys_p2 + pr_p2);
      g_p3 <= round_q8(ys_p2 - pgb_p2 - pgr_p2);
      b_p3 <= round_q8(ys_p2 + pb_p2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {vld_p0, vld_p1, vld_p2, vld_p3} <= '0;
      {sop_p0, sop_p1, sop_p2, sop_p3} <= '0;
      {eop_p0, eop_p1, eop_p2, eop_p3} <= '0;
    end else if (en) begin
      vld_p0 <= accept;
      sop_p0 <= accept & sop_in;
      eop_p0 <= accept & eop_in;
      vld_p1 <= vld_p0;  sop_p1 <= sop_p0;  eop_p1 <= eop_p0;
      vld_p2 <= vld_p1;  sop_p2 <= sop_p1;  eop_p2 <= eop_p1;
      vld_p3 <= vld_p2;  sop_p3 <= sop_p2;  eop_p3 <= eop_p2;
    end
  end

  // p4: clamp and present; lane 2 = R, lane 1 = G, lane 0 = B
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) bus.out[i] <= '0;
    end else if (en) begin
      for (int i = 0; i < 3; i++) begin
        bus.out[i].valid <= vld_p3;
        bus.out[i].sop   <= sop_p3;
        bus.out[i].eop   <= eop_p3;
      end
      bus.out[2].data <= sat_u8(r_p3);
      bus.out[1].data <= sat_u8(g_p3);
      bus.out[0].data <= sat_u8(b_p3);
    end
  end

`ifdef YCBCR2RGB_PROTO_EN
  typedef enum logic {S_IDLE, S_ACTIVE} state_t;
  state_t state, state_nxt;
  logic   err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      proto_err <= err_nxt;
    end
  end

  // A sop inside a frame flags an error but restarts the frame.
  always_comb begin
    state_nxt = state;
    err_nxt   = proto_err;
    if (accept) begin
      case (state)
        S_IDLE: begin
          if (!sop_in)      err_nxt   = 1'b1;
          else if (!eop_in) state_nxt = S_ACTIVE;
        end
        S_ACTIVE: begin
          if (sop_in) err_nxt   = 1'b1;
          if (eop_in) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.in[0].data[DATA_WIDTH-1:8], bus.in[1].data[DATA_WIDTH-1:8],
                         bus.in[2].data[DATA_WIDTH-1:8]};
`else
  assign proto_err = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{bus.in[0].data[DATA_WIDTH-1:8], bus.in[1].data[DATA_WIDTH-1:8],
                         bus.in[2].data[DATA_WIDTH-1:8], sop_in, eop_in};
`endif
endmodule

// File: tb/tb_ycbcr2rgb.sv
// Scoreboard bench for ycbcr2rgb: randomized and directed sample sets checked
// against an integer reference model of the colour conversion and frame protocol.
module tb_ycbcr2rgb;
  localparam int W = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic proto_err;

  always #5 clk = ~clk;

  ycbcr2rgb_if #(.DATA_WIDTH(W)) bus ();
  ycbcr2rgb #(.DATA_WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .proto_err(proto_err));

  typedef struct { int r; int g; int b; bit sop; bit eop; } pix_t;

  pix_t sb[$];
  int   nchk = 0;
  int   nerr = 0;
  bit   m_in_frame = 1'b0;
  bit   m_err = 1'b0;
  bit   held = 1'b0;
  pix_t held_v;
  pix_t cur;
  pix_t e;

  function automatic int floor_div256(int n);
    return (n >= 0) ? n / 256 : -((-n + 255) / 256);
  endfunction

  function automatic int clamp8(int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  function automatic pix_t model(int y, int cb, int cr, bit s, bit eo);
    pix_t p;
    p.r = clamp8(floor_div256(256 * y + 359 * (cr - 128) + 128));
    p.g = clamp8(floor_div256(256 * y - 88 * (cb - 128) - 183 * (cr - 128) + 128));
    p.b = clamp8(floor_div256(256 * y + 454 * (cb - 128) + 128));
    p.sop = s;
    p.eop = eo;
    return p;
  endfunction

  function automatic int exp_err();
`ifdef YCBCR2RGB_PROTO_EN
    return int'(m_err);
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int y, input int cb, input int cr, input bit [2:0] vm,
                       input bit [2:0] s, input bit [2:0] eo, input bit ordy);
    @(negedge clk);
    bus.in[0].data = W'(y);
    bus.in[1].data = W'(cr);
    bus.in[2].data = W'(cb);
    for (int i = 0; i < 3; i++) begin
      bus.in[i].valid = vm[i];
      bus.in[i].sop   = s[i];
      bus.in[i].eop   = eo[i];
    end
    bus.out_ready = ordy;
    if (rst_n && (&vm) && ordy) begin
      sb.push_back(model(y, cb, cr, |s, |eo));
      if (!m_in_frame) begin
        if (!(|s)) m_err = 1'b1;
        else       m_in_frame = !(|eo);
      end else begin
        if (|s) m_err = 1'b1;
        m_in_frame = !(|eo);
      end
    end
  endtask

  task automatic idle(input bit ordy);
    drive(0, 0, 0, 3'b000, 3'b000, 3'b000, ordy);
  endtask

  task automatic chk_out_zero(input string name);
    for (int i = 0; i < 3; i++) begin
      chk(name, int'({bus.out[i].data, bus.out[i].valid, bus.out[i].sop, bus.out[i].eop}), 0);
    end
    chk({name, "_proto"}, int'(proto_err), 0);
  endtask

  // Output monitor: a transfer happens on the next rising edge when valid and out_ready are both high.
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      cur.r   = int'(bus.out[2].data);
      cur.g   = int'(bus.out[1].data);
      cur.b   = int'(bus.out[0].data);
      cur.sop = bus.out[0].sop;
      cur.eop = bus.out[0].eop;
      if (held && !bus.out[0].valid) chk("stall_valid_drop", 0, 1);
      if (bus.out[0].valid) begin
        chk("lane_valid", int'({bus.out[1].valid, bus.out[2].valid}), 3);
        chk("lane_sop", int'({bus.out[1].sop, bus.out[2].sop}), cur.sop ? 3 : 0);
        chk("lane_eop", int'({bus.out[1].eop, bus.out[2].eop}), cur.eop ? 3 : 0);
        if (held) begin
          chk("stall_hold_R", cur.r, held_v.r);
          chk("stall_hold_G", cur.g, held_v.g);
          chk("stall_hold_B", cur.b, held_v.b);
          chk("stall_hold_flags", int'({cur.sop, cur.eop}), int'({held_v.sop, held_v.eop}));
        end
        if (bus.out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("R", cur.r, e.r);
            chk("G", cur.g, e.g);
            chk("B", cur.b, e.b);
            chk("sop", int'(cur.sop), int'(e.sop));
            chk("eop", int'(cur.eop), int'(e.eop));
          end
          held = 1'b0;
        end else begin
          held   = 1'b1;
          held_v = cur;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  int sy[8], scb[8], scr[8];
  int idx, lowcnt;
  bit ordy;
  bit [2:0] vm, s, eo;

  initial begin
    for (int i = 0; i < 3; i++) bus.in[i] = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk_out_zero("reset_state");
    bus.out_ready = 1'b0;
    #1 chk("in_ready_in_reset_lo", int'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    #1 chk("in_ready_in_reset_hi", int'(bus.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) idle(1'b1);

    // Neutral grey, single-sample frame, with latency check.
    drive(128, 128, 128, 3'b111, 3'b001, 3'b100, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      idle(1'b1);
      #2;
      chk("latency_valid", int'(bus.out[0].valid), int'(k == 5));
      if (k == 5) begin
        chk("grey_R", int'(bus.out[2].data), 128);
        chk("grey_G", int'(bus.out[1].data), 128);
        chk("grey_B", int'(bus.out[0].data), 128);
        chk("grey_sop_eop", int'({bus.out[0].sop, bus.out[0].eop}), 3);
      end
    end

    // Clamping corners, back to back.
    drive(255, 128, 255, 3'b111, 3'b010, 3'b000, 1'b1);
    drive(0, 0, 0, 3'b111, 3'b000, 3'b001, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      idle(1'b1);
      #2;
      if (k == 4) begin
        chk("hi_R", int'(bus.out[2].data), 255);
        chk("hi_G", int'(bus.out[1].data), 164);
        chk("hi_B", int'(bus.out[0].data), 255);
      end
      if (k == 5) begin
        chk("lo_R", int'(bus.out[2].data), 0);
        chk("lo_G", int'(bus.out[1].data), 136);
        chk("lo_B", int'(bus.out[0].data), 0);
      end
    end
    chk("proto_clean", int'(proto_err), 0);

    // Eight-set frame with out_ready low on stream cycles 3..5.
    for (int i = 0; i < 8; i++) begin
      sy[i]  = int'($urandom_range(0, 255));
      scb[i] = int'($urandom_range(0, 255));
      scr[i] = int'($urandom_range(0, 255));
    end
    idx = 0;
    lowcnt = 0;
    for (int c = 0; idx < 8 && c < 40; c++) begin
      ordy = !(c >= 3 && c <= 5);
      drive(sy[idx], scb[idx], scr[idx], 3'b111, {2'b00, idx == 0}, {idx == 7, 2'b00}, ordy);
      #2;
      chk("in_ready_follow", int'(bus.in_ready), int'(ordy));
      if (!bus.in_ready) lowcnt++;
      if (ordy) idx++;
    end
    chk("stall_cycles", lowcnt, 3);
    repeat (8) idle(1'b1);
    chk("stream_drained", sb.size(), 0);
    chk("proto_after_frames", int'(proto_err), 0);

    // Valid without sop from IDLE.
    drive(50, 60, 70, 3'b111, 3'b000, 3'b000, 1'b1);
    idle(1'b1);
    #2 chk("proto_err_set", int'(proto_err), exp_err());
    repeat (3) idle(1'b1);
    #2 chk("proto_err_sticky", int'(proto_err), exp_err());

    // Randomized traffic with backpressure and a mid-stream reset.
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        m_in_frame = 1'b0;
        m_err = 1'b0;
        #2 chk_out_zero("mid_reset");
        repeat (2) idle(1'b1);
        rst_n = 1'b1;
        repeat (8) idle(1'b1);
        chk("post_reset_proto", int'(proto_err), 0);
      end
      vm   = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
      s    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      eo   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      ordy = ($urandom_range(0, 3) != 0);
      drive(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), vm, s, eo, ordy);
    end
    idle(1'b1);
    #2 chk("proto_random", int'(proto_err), exp_err());
    repeat (12) idle(1'b1);
    chk("final_drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
